pipeline_stage: RTL

PIPELINE_STAGE -- requirements
Module: pipeline_stage

---
 rtl/pipeline_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipeline_stage.sv
// pipeline_stage: registered hand-off stage between two valid/ready ports.
// Each entry carries a PC, an instruction word and a halt flag.
// Build option: define PIPELINE_STAGE_SKID_EN for a two-entry skid buffer
// whose in_ready does not depend on out_ready. Leave it undefined for a
// single-entry stage whose in_ready passes out_ready straight through.
// Accepting a halt entry locks the input side until the next flush or reset.
module pipeline_stage #(
   parameter int unsigned        DATA_W  = 32,
   parameter int unsigned        PC_W    = 16,
   parameter logic [DATA_W-1:0]  NOP_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              hold,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic              out_halt,
   output logic [1:0]        count,
   output logic              halt_lock
);

   typedef struct packed {
      logic              halt;
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t     slot0_q, slot0_d;
`ifdef PIPELINE_STAGE_SKID_EN
   entry_t     slot1_q, slot1_d;
   logic [1:0] fill_lvl;
`endif
   logic [1:0] count_q, count_d;
   logic       halt_lock_q, halt_lock_d;
   logic       has_entry;
   logic       accept;
   logic       emit;
   entry_t     in_entry;

   assign in_entry  = {in_halt, in_pc, in_data};
   assign has_entry = (count_q != 2'd0);

   // Handshake: flush and hold block both sides; an empty stage never presents.
   assign out_valid = has_entry & ~hold & ~flush;
`ifdef PIPELINE_STAGE_SKID_EN
   assign in_ready  = rst & ~hold & ~flush & ~halt_lock_q & (count_q != 2'd2);
`else
   assign in_ready  = rst & ~hold & ~flush & ~halt_lock_q & (~has_entry | out_ready);
`endif
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;

   // Stale slot contents are masked so only a presented entry reaches the port.
   assign out_data  = out_valid ? slot0_q.data : NOP_VAL;
   assign out_pc    = out_valid ? slot0_q.pc   : '0;
   assign out_halt  = out_valid & slot0_q.halt;
   assign count     = count_q;
   assign halt_lock = halt_lock_q;

`ifdef PIPELINE_STAGE_SKID_EN
   // Occupancy after this cycle's emit; selects which slot a new entry lands in.
   assign fill_lvl = count_q - {1'b0, emit};
`endif

   // Next-state: shift on emit, append on accept, flush wipes everything.
   always_comb begin
      slot0_d     = slot0_q;
`ifdef PIPELINE_STAGE_SKID_EN
      slot1_d     = slot1_q;
`endif
      count_d     = count_q;
      halt_lock_d = halt_lock_q;
      if (flush) begin
         count_d     = 2'd0;
         halt_lock_d = 1'b0;
      end else begin
         count_d = count_q - {1'b0, emit} + {1'b0, accept};
         if (accept & in_halt) begin
            halt_lock_d = 1'b1;
         end
`ifdef PIPELINE_STAGE_SKID_EN
         if (emit) begin
            slot0_d = slot1_q;
         end
         if (accept) begin
            if (fill_lvl == 2'd0) begin
               slot0_d = in_entry;
            end else begin
               slot1_d = in_entry;
            end
         end
`else
         if (accept) begin
            slot0_d = in_entry;
         end
`endif
      end
   end

   // State registers; reset discards every held entry and the halt lock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot0_q     <= '0;
`ifdef PIPELINE_STAGE_SKID_EN
         slot1_q     <= '0;
`endif
         count_q     <= 2'd0;
         halt_lock_q <= 1'b0;
      end else begin
         slot0_q     <= slot0_d;
`ifdef PIPELINE_STAGE_SKID_EN
         slot1_q     <= slot1_d;
`endif
         count_q     <= count_d;
         halt_lock_q <= halt_lock_d;
      end
   end

endmodule
